jtag_tap_master: RTL and testbench
==================================

// Module: jtag_tap_master
// PURPOSE
//  Host-side JTAG driver: the initiating end of the TAP protocol. Turns one-word commands from a
//  system-side requester into TCK/TMS/TDI waveforms that walk a target TAP controller through IR/DR
//  scans, and returns the TDO bits captured during shifting. Sits between the debug/test command
//  source and the JTAG pins of the target. Internally mirrors the target TAP state (state_t).
// PARAMETERS
//  MAX_LEN   32  max bits per scan and max IDLE count; rsp_tdo/cmd_tdi width
//  CLK_DIV   2   TCK half-period in CLK cycles (>=1); TCK freq = CLK/(2*CLK_DIV)
// PORTS
//  CLK        in   1                      system clock; all logic on posedge
//  TRST       in   1                      reset, asynchronous, active-low
//  cmd_valid  in   1                      command present
//  cmd_ready  out  1                      master accepts command this cycle
//  cmd_op     in   2                      jtag_cmd_op_t: RESET=0, IDLE=1, SCAN_IR=2, SCAN_DR=3
//  cmd_len    in   $clog2(MAX_LEN+1)      shift bit count (SCAN_*) or TCK count (IDLE)
//  cmd_tdi    in   MAX_LEN                shift data, LSB shifted first
//  rsp_valid  out  1                      scan result available (SCAN_* only)
//  rsp_ready  in   1                      requester takes result
//  rsp_tdo    out  MAX_LEN                captured TDO, bit i = i-th shifted bit; bits >= len are 0
//  busy       out  1                      high from command accept until back in READY
//  TCK        out  1                      JTAG clock, idles low
//  TMS        out  1                      JTAG mode select
//  TDI        out  1                      JTAG data to target
//  TDO        in   1                      JTAG data from target
// BEHAVIOUR
//  Reset (TRST low, async): TCK=0 TMS=1 TDI=0 cmd_ready=0 rsp_valid=0 rsp_tdo=0 busy=1; FSM=INIT.
//  TCK gen: each TCK period = CLK_DIV CLK low + CLK_DIV CLK high. TMS/TDI change only on the CLK edge
//   where TCK falls; TDO sampled on the CLK edge where TCK rises. Mirror state advances at TCK rise.
//  FSM: INIT -> READY -> HEAD -> SHIFT -> TAIL -> RESP -> READY (HEAD/TAIL/SHIFT skipped per op).
//  INIT: after TRST release, 6 TCKs with TMS=1,1,1,1,1,0 -> mirror=RUN_TEST_IDLE -> READY.
//  READY: cmd_ready = 1 iff FSM=READY and rsp_valid=0. Accept on cmd_valid&&cmd_ready; latch op/len/tdi.
//   Every command starts and ends with target in RUN_TEST_IDLE.
//  RESET: TMS=1,1,1,1,1,0 (6 TCKs); no response.
//  IDLE : len TCKs with TMS=0; len=0 -> no TCK, back to READY next CLK; no response.
//  SCAN_DR: HEAD TMS=1,0,0 (SelDR,CapDR,ShiftDR); SHIFT len TCKs, TDI=tdi[i], TMS=0 except 1 on last
//   (->Exit1DR); TAIL TMS=1,0 (UpdateDR, RTI). Total len+5 TCKs.
//  SCAN_IR: HEAD TMS=1,1,0,0; same SHIFT; TAIL TMS=1,0. Total len+6 TCKs.
//  len=1: single shift TCK carries TMS=1. len=0: no TCK, rsp_tdo=0, response still issued.
//   len>MAX_LEN: saturated to MAX_LEN.
//  TDO bit i stored in rsp_tdo[i] at TCK rise of shift cycle i; unused bits zero.
//  RESP: rsp_valid=1, rsp_tdo stable until rsp_valid&&rsp_ready; then READY next CLK.
//   No new command accepted while rsp_valid=1.
//  TDI=0 outside SHIFT. busy=0 only in READY.
//  TRST asserted mid-command: immediate reset values, pending response dropped, INIT re-run on release.
//  Mirror state uses the standard 16-state TAP transition table; must equal RUN_TEST_IDLE in READY
//   (assertion).
// STRUCTURE
//  jtag_types_pkg: reuse state_t; add jtag_cmd_op_t enum (2 bits) and RESET_TMS_LEN=6 constant.
//  Sub-module jtag_tck_gen: CLK_DIV counter, outputs TCK plus one-CLK tck_fall/tck_rise strobes,
//   enable input (TCK parked low when disabled). FSM, shift regs and mirror state in top.
// TESTING (bench instantiates target tap_ctrl on TCK/TMS/TRST to check state walks)
//  1 Release TRST -> exactly 6 TCK rises, TMS=1,1,1,1,1,0; cmd_ready=1 after; target in RUN_TEST_IDLE.
//  2 SCAN_IR len=4 tdi=4'b0101 -> TMS seq 1,1,0,0,0,0,0,1,1,0 (10 TCKs); target ir_shift high 4 TCKs,
//    ir_update 1 TCK; TDI bits 1,0,1,0.
//  3 SCAN_DR len=32 tdi=32'hDEADBEEF, TDO wired to TDI -> 37 TCKs, rsp_tdo=32'hDEADBEEF;
//    len=1 tdi=1 -> rsp_tdo=32'h1.
//  4 Hold rsp_ready=0 for 20 CLK after SCAN_DR -> rsp_valid/rsp_tdo stable, cmd_ready=0, no TCK edges.
//  5 IDLE len=0 -> no TCK, cmd_ready back within 2 CLK; IDLE len=3 -> 3 TCKs TMS=0.
//    SCAN_DR len=0 -> rsp_tdo=0, no TCK.
//  6 Assert TRST mid SCAN_DR (bit 10) -> TCK=0 TMS=1 rsp_valid=0 at once; on release 6-TCK reset
//    replays, next command OK.

Source files
------------

// File: rtl/jtag_types_pkg.sv
// Shared JTAG types: target TAP state encoding, host command opcodes and the
// standard 16-state TAP transition function used to mirror the target.
package jtag_types_pkg;

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'd0,
        RUN_TEST_IDLE    = 4'd1,
        SELECT_DR_SCAN   = 4'd2,
        CAPTURE_DR       = 4'd3,
        SHIFT_DR         = 4'd4,
        EXIT1_DR         = 4'd5,
        PAUSE_DR         = 4'd6,
        EXIT2_DR         = 4'd7,
        UPDATE_DR        = 4'd8,
        SELECT_IR_SCAN   = 4'd9,
        CAPTURE_IR       = 4'd10,
        SHIFT_IR         = 4'd11,
        EXIT1_IR         = 4'd12,
        PAUSE_IR         = 4'd13,
        EXIT2_IR         = 4'd14,
        UPDATE_IR        = 4'd15
    } state_t;

    typedef enum logic [1:0] {
        OP_RESET   = 2'd0,
        OP_IDLE    = 2'd1,
        OP_SCAN_IR = 2'd2,
        OP_SCAN_DR = 2'd3
    } jtag_cmd_op_t;

    typedef enum logic [2:0] {
        M_INIT  = 3'd0,
        M_READY = 3'd1,
        M_HEAD  = 3'd2,
        M_SHIFT = 3'd3,
        M_TAIL  = 3'd4,
        M_RESP  = 3'd5
    } master_state_t;

    localparam int RESET_TMS_LEN = 6;

    function automatic state_t tap_next(input state_t s, input logic tms);
        state_t n;
        case (s)
            TEST_LOGIC_RESET: n = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   n = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
            CAPTURE_DR:       n = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         n = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         n = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         n = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         n = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   n = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       n = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         n = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         n = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         n = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         n = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            default:          n = TEST_LOGIC_RESET;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_tap_master_chk.sv
// Protocol checker: whenever the master is ready for a command the mirrored
// target TAP must be parked in Run-Test/Idle.
module jtag_tap_master_chk
    import jtag_types_pkg::*;
(
    input logic   i_clk,
    input logic   i_rst_n,
    input logic   i_ready,
    input state_t i_tap
);

    a_ready_in_rti: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_ready |-> (i_tap == RUN_TEST_IDLE));

endmodule

// File: rtl/jtag_tck_gen.sv
// TCK generator: CLK_DIV system clocks low then CLK_DIV high per TCK period,
// with strobes that flag the CLK edge on which TCK is about to rise or fall.
module jtag_tck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_tck,
    output logic o_tck_rise,
    output logic o_tck_fall
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tck;
    logic          w_wrap;

    assign w_wrap     = i_en && (r_cnt == CNT_MAX);
    assign o_tck_rise = w_wrap && !r_tck;
    assign o_tck_fall = w_wrap && r_tck;
    assign o_tck      = r_tck;

    // Half-period counter; TCK is parked low whenever the generator is disabled
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_tck <= 1'b0;
        end else if (!i_en) begin
            r_cnt <= '0;
            r_tck <= 1'b0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_tck <= ~r_tck;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/jtag_tap_master.sv
// Host-side JTAG TAP master: turns one-word commands into TCK/TMS/TDI walks of
// the target TAP and returns the TDO bits captured while shifting.
module jtag_tap_master
    import jtag_types_pkg::*;
#(
    parameter int MAX_LEN = 32,
    parameter int CLK_DIV = 2
) (
    input  logic                         CLK,
    input  logic                         TRST,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  jtag_cmd_op_t                 cmd_op,
    input  logic [$clog2(MAX_LEN+1)-1:0] cmd_len,
    input  logic [MAX_LEN-1:0]           cmd_tdi,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [MAX_LEN-1:0]           rsp_tdo,
    output logic                         busy,
    output logic                         TCK,
    output logic                         TMS,
    output logic                         TDI,
    input  logic                         TDO
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    master_state_t      r_state, w_next_state, w_ph;
    jtag_cmd_op_t       r_op;
    state_t             r_tap;
    logic [LEN_W-1:0]   r_idx, w_next_idx, r_len, w_cmd_len, w_phase_len;
    logic [MAX_LEN-1:0] r_tdi, r_tdo;
    logic               r_tms, w_next_tms, r_tdi_bit, w_next_tdi, r_last;
    logic               w_accept, w_en, w_rise, w_fall;

    // TMS for TCK number idx of a phase; every command ends back in Run-Test/Idle
    function automatic logic tms_for(input master_state_t st, input jtag_cmd_op_t op,
                                     input logic [LEN_W-1:0] idx, input logic [LEN_W-1:0] len);
        logic t;
        case (st)
            M_INIT:  t = (idx < LEN_W'(RESET_TMS_LEN - 1));
            M_HEAD:  t = (op == OP_SCAN_IR) ? (idx < LEN_W'(2)) :
                         (op == OP_SCAN_DR) ? (idx == '0) : 1'b0;
            M_SHIFT: t = (idx == len - 1'b1);
            M_TAIL:  t = (idx == '0);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    function automatic master_state_t next_phase(input master_state_t st, input jtag_cmd_op_t op);
        master_state_t n;
        case (st)
            M_HEAD:  n = (op == OP_IDLE) ? M_READY : M_SHIFT;
            M_SHIFT: n = M_TAIL;
            M_TAIL:  n = M_RESP;
            default: n = M_READY;
        endcase
        return n;
    endfunction

    assign w_cmd_len = (cmd_len > MAX_L) ? MAX_L : cmd_len;
    assign w_en      = (r_state == M_INIT) || (r_state == M_HEAD) ||
                       (r_state == M_SHIFT) || (r_state == M_TAIL);
    assign w_ph      = next_phase(r_state, r_op);

    jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
        .i_clk      (CLK),
        .i_rst_n    (TRST),
        .i_en       (w_en),
        .o_tck      (TCK),
        .o_tck_rise (w_rise),
        .o_tck_fall (w_fall)
    );

    // TCK count of the phase currently being clocked out
    always_comb begin
        w_phase_len = LEN_W'(1);
        case (r_state)
            M_INIT:  w_phase_len = LEN_W'(RESET_TMS_LEN);
            M_HEAD:  w_phase_len = (r_op == OP_IDLE)    ? r_len :
                                   (r_op == OP_SCAN_IR) ? LEN_W'(4) : LEN_W'(3);
            M_SHIFT: w_phase_len = r_len;
            M_TAIL:  w_phase_len = LEN_W'(2);
            default: w_phase_len = LEN_W'(1);
        endcase
    end

    // Next state; phase changes happen on the TCK fall after a phase's last rise
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_next_tms   = r_tms;
        w_next_tdi   = r_tdi_bit;
        w_accept     = 1'b0;
        case (r_state)
            M_READY: begin
                if (cmd_valid) begin
                    w_accept   = 1'b1;
                    w_next_idx = '0;
                    case (cmd_op)
                        OP_RESET: begin
                            w_next_state = M_INIT;
                            w_next_tms   = 1'b1;
                        end
                        OP_IDLE: w_next_state = (w_cmd_len == '0) ? M_READY : M_HEAD;
                        default: begin
                            if (w_cmd_len == '0) begin
                                w_next_state = M_RESP;
                            end else begin
                                w_next_state = M_HEAD;
                                w_next_tms   = 1'b1;
                            end
                        end
                    endcase
                end else begin
                    w_accept = 1'b0;
                end
            end
            M_INIT, M_HEAD, M_SHIFT, M_TAIL: begin
                if (w_fall && r_last) begin
                    w_next_state = w_ph;
                    w_next_idx   = '0;
                    w_next_tms   = tms_for(w_ph, r_op, '0, r_len);
                    w_next_tdi   = (w_ph == M_SHIFT) ? r_tdi[0] : 1'b0;
                end else if (w_fall) begin
                    w_next_idx   = r_idx + 1'b1;
                    w_next_tms   = tms_for(r_state, r_op, r_idx + 1'b1, r_len);
                    w_next_tdi   = (r_state == M_SHIFT) ? r_tdi[1] : 1'b0;
                end else begin
                    w_next_state = r_state;
                end
            end
            M_RESP: begin
                if (rsp_ready) begin
                    w_next_state = M_READY;
                end else begin
                    w_next_state = M_RESP;
                end
            end
            default: w_next_state = M_INIT;
        endcase
    end

    // FSM state plus the pin registers that follow it
    always_ff @(posedge CLK or negedge TRST) begin
        if (!TRST) begin
            r_state   <= M_INIT;
            r_idx     <= '0;
            r_tms     <= 1'b1;
            r_tdi_bit <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_idx     <= w_next_idx;
            r_tms     <= w_next_tms;
            r_tdi_bit <= w_next_tdi;
        end
    end

    // Command latch, TDO capture (MSB-in, right-aligned after the last bit) and TAP mirror
    always_ff @(posedge CLK or negedge TRST) begin
        if (!TRST) begin
            r_op   <= OP_RESET;
            r_len  <= '0;
            r_tdi  <= '0;
            r_tdo  <= '0;
            r_last <= 1'b0;
            r_tap  <= TEST_LOGIC_RESET;
        end else if (w_accept) begin
            r_op   <= cmd_op;
            r_len  <= w_cmd_len;
            r_tdi  <= cmd_tdi;
            r_tdo  <= '0;
            r_last <= 1'b0;
        end else if (w_rise) begin
            r_tap  <= tap_next(r_tap, r_tms);
            r_last <= (r_idx == w_phase_len - 1'b1);
            if (r_state == M_SHIFT) begin
                r_tdo <= {TDO, r_tdo[MAX_LEN-1:1]};
            end
        end else if (w_fall && (r_state == M_SHIFT)) begin
            if (r_last) begin
                r_tdo <= r_tdo >> (MAX_L - r_len);
            end else begin
                r_tdi <= r_tdi >> 1;
            end
        end
    end

    assign cmd_ready = (r_state == M_READY);
    assign rsp_valid = (r_state == M_RESP);
    assign busy      = (r_state != M_READY);
    assign rsp_tdo   = r_tdo;
    assign TMS       = r_tms;
    assign TDI       = r_tdi_bit;

    jtag_tap_master_chk u_chk (
        .i_clk   (CLK),
        .i_rst_n (TRST),
        .i_ready (cmd_ready),
        .i_tap   (r_tap)
    );

endmodule

// File: tb/tb_jtag_tap_master.sv
// Self-checking bench for jtag_tap_master: a behavioural target TAP watches the
// pins while expected TCK/TMS/TDI/TDO sequences are built from the command rules.
module tb_jtag_tap_master;
    import jtag_types_pkg::*;

    logic         CLK = 1'b0;
    logic         TRST = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    jtag_cmd_op_t cmd_op = OP_IDLE;
    logic [5:0]   cmd_len = 6'd0;
    logic [31:0]  cmd_tdi = 32'd0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [31:0]  rsp_tdo;
    logic         busy, TCK, TMS, TDI, TDO;
    logic         tdo_inv = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural target: pin recorder and TAP walk (T_* codes are bench-local)
    localparam int T_TLR = 0, T_RTI = 1, T_SDR = 2, T_CDR = 3, T_SHD = 4, T_E1D = 5,
                   T_PDR = 6, T_E2D = 7, T_UDR = 8, T_SIR = 9, T_CIR = 10, T_SHI = 11,
                   T_E1I = 12, T_PIR = 13, T_E2I = 14, T_UIR = 15;
    int          tgt = T_TLR;
    int          tck_cnt = 0, ir_sh = 0, ir_up = 0, dr_sh = 0;
    logic [63:0] rec_tms = '0, rec_tdi = '0;

    assign TDO = TDI ^ tdo_inv;

    always #5 CLK = ~CLK;

    jtag_tap_master #(.MAX_LEN(32), .CLK_DIV(2)) dut (
        .CLK(CLK), .TRST(TRST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_tdi(cmd_tdi), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_tdo(rsp_tdo), .busy(busy), .TCK(TCK), .TMS(TMS),
        .TDI(TDI), .TDO(TDO)
    );

    always @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            tgt = T_TLR;
        end else begin
            if (tck_cnt < 64) begin
                rec_tms[tck_cnt] = TMS;
                rec_tdi[tck_cnt] = TDI;
            end
            tck_cnt++;
            if (tgt == T_SHI) ir_sh++;
            if (tgt == T_UIR) ir_up++;
            if (tgt == T_SHD) dr_sh++;
            case (tgt)
                T_TLR: tgt = TMS ? T_TLR : T_RTI;
                T_RTI: tgt = TMS ? T_SDR : T_RTI;
                T_SDR: tgt = TMS ? T_SIR : T_CDR;
                T_CDR: tgt = TMS ? T_E1D : T_SHD;
                T_SHD: tgt = TMS ? T_E1D : T_SHD;
                T_E1D: tgt = TMS ? T_UDR : T_PDR;
                T_PDR: tgt = TMS ? T_E2D : T_PDR;
                T_E2D: tgt = TMS ? T_UDR : T_SHD;
                T_UDR: tgt = TMS ? T_SDR : T_RTI;
                T_SIR: tgt = TMS ? T_TLR : T_CIR;
                T_CIR: tgt = TMS ? T_E1I : T_SHI;
                T_SHI: tgt = TMS ? T_E1I : T_SHI;
                T_E1I: tgt = TMS ? T_UIR : T_PIR;
                T_PIR: tgt = TMS ? T_E2I : T_PIR;
                T_E2I: tgt = TMS ? T_UIR : T_SHI;
                default: tgt = TMS ? T_SDR : T_RTI;
            endcase
        end
    end

    function automatic int sat(input logic [5:0] len);
        return (len > 6'd32) ? 32 : int'(len);
    endfunction

    function automatic int exp_cnt(input logic [1:0] op, input int L);
        case (op)
            2'd0:    return 6;
            2'd1:    return L;
            2'd2:    return (L == 0) ? 0 : L + 6;
            default: return (L == 0) ? 0 : L + 5;
        endcase
    endfunction

    // TMS per TCK: head (1,1,0,0 for IR / 1,0,0 for DR), len shifts ending on 1, tail 1,0
    function automatic logic [63:0] exp_tms(input logic [1:0] op, input int L);
        logic [63:0] v;
        int k;
        v = '0;
        if (op == 2'd0) begin
            v[4:0] = 5'h1F;
        end else if (op >= 2'd2 && L > 0) begin
            k = (op == 2'd2) ? 4 : 3;
            v[0] = 1'b1;
            if (op == 2'd2) v[1] = 1'b1;
            v[k+L-1] = 1'b1;
            v[k+L]   = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [63:0] exp_tdi(input logic [1:0] op, input int L, input logic [31:0] d);
        logic [63:0] v;
        int k;
        v = '0;
        k = (op == 2'd2) ? 4 : 3;
        if (op >= 2'd2)
            for (int i = 0; i < L; i++) v[k+i] = d[i];
        return v;
    endfunction

    function automatic logic [31:0] exp_rsp(input int L, input logic [31:0] d, input logic inv);
        logic [63:0] m;
        m = (64'd1 << L) - 64'd1;
        return (d ^ {32{inv}}) & m[31:0];
    endfunction

    // Issue one command and wait for it to finish (response acked if auto_ack)
    task automatic run_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] d,
                           input logic inv, input bit auto_ack, output bit to, output logic [31:0] rsp);
        bit ok;
        to  = 1'b0;
        rsp = '0;
        @(negedge CLK);
        tck_cnt = 0; ir_sh = 0; ir_up = 0; dr_sh = 0; rec_tms = '0; rec_tdi = '0;
        tdo_inv = inv; cmd_op = jtag_cmd_op_t'(op); cmd_len = len; cmd_tdi = d; cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            if (cmd_ready) ok = 1'b1;
            else @(negedge CLK);
        end
        @(posedge CLK);
        #1 cmd_valid = 1'b0;
        if (!ok) begin
            to = 1'b1;
        end else begin
            @(negedge CLK);
            ok = 1'b0;
            for (int i = 0; i < 2000 && !ok; i++) begin
                if ((op >= 2'd2) ? rsp_valid : cmd_ready) ok = 1'b1;
                else @(negedge CLK);
            end
            to = !ok;
            if (ok && op >= 2'd2) begin
                rsp = rsp_tdo;
                if (auto_ack) begin
                    rsp_ready = 1'b1;
                    @(negedge CLK);
                    rsp_ready = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge CLK);
            if (cmd_ready) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        bit ok;
        #3 TRST = 1'b0;
        #20;
        n_tests++;
        if ({TCK, TMS, TDI, cmd_ready, rsp_valid, busy} !== 6'b010001 || rsp_tdo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_values: got TCK%b TMS%b TDI%b rdy%b vld%b busy%b tdo=%h, want 0 1 0 0 0 1 0",
                     TCK, TMS, TDI, cmd_ready, rsp_valid, busy, rsp_tdo);
        end
        tck_cnt = 0; rec_tms = '0;
        @(negedge CLK) TRST = 1'b1;
        wait_ready(ok);
        n_tests++;
        if (!ok || tck_cnt !== 6 || rec_tms[5:0] !== 6'b011111 || tgt !== T_RTI) begin
            n_fail++;
            $display("FAIL reset_walk: ready=%b tcks=%0d tms=%b tgt=%0d, want 1 6 011111 %0d",
                     ok, tck_cnt, rec_tms[5:0], tgt, T_RTI);
        end
    endtask

    task automatic test_scan_ir();
        bit to;
        logic [31:0] r;
        run_cmd(2'd2, 6'd4, 32'h5, 1'b1, 1'b1, to, r);
        n_tests++;
        if (to || tck_cnt !== 10 || rec_tms[9:0] !== 10'b0110000011 || rec_tdi[9:0] !== 10'b0001010000) begin
            n_fail++;
            $display("FAIL scan_ir_pins: to=%b tcks=%0d tms=%b tdi=%b", to, tck_cnt, rec_tms[9:0], rec_tdi[9:0]);
        end
        n_tests++;
        if (ir_sh !== 4 || ir_up !== 1 || tgt !== T_RTI || r !== 32'hA) begin
            n_fail++;
            $display("FAIL scan_ir_target: shift=%0d upd=%0d tgt=%0d rsp=%h, want 4 1 %0d 0000000a",
                     ir_sh, ir_up, tgt, T_RTI, r);
        end
    endtask

    task automatic test_scan_dr();
        bit to;
        logic [31:0] r;
        run_cmd(2'd3, 6'd32, 32'hDEADBEEF, 1'b0, 1'b1, to, r);
        n_tests++;
        if (to || tck_cnt !== 37 || r !== 32'hDEADBEEF || dr_sh !== 32 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL scan_dr_32: to=%b tcks=%0d rsp=%h shifts=%0d busy=%b, want 0 37 deadbeef 32 0",
                     to, tck_cnt, r, dr_sh, busy);
        end
        run_cmd(2'd3, 6'd1, 32'h1, 1'b0, 1'b1, to, r);
        n_tests++;
        if (to || tck_cnt !== 6 || r !== 32'h1 || rec_tms[5:0] !== 6'b011001) begin
            n_fail++;
            $display("FAIL scan_dr_1: to=%b tcks=%0d rsp=%h tms=%b, want 0 6 00000001 011001",
                     to, tck_cnt, r, rec_tms[5:0]);
        end
    endtask

    task automatic test_resp_hold();
        bit to;
        logic [31:0] r, d;
        int cnt0, bad;
        d = $urandom;
        run_cmd(2'd3, 6'd16, d, 1'b0, 1'b0, to, r);
        cnt0 = tck_cnt; bad = 0;
        cmd_op = OP_IDLE; cmd_len = 6'd3; cmd_valid = 1'b1;
        repeat (20) begin
            @(negedge CLK);
            if (!rsp_valid || rsp_tdo !== r || cmd_ready) bad++;
        end
        n_tests++;
        if (to || bad !== 0 || tck_cnt !== cnt0 || r !== exp_rsp(16, d, 1'b0)) begin
            n_fail++;
            $display("FAIL resp_hold: to=%b bad_cycles=%0d tcks=%0d/%0d rsp=%h want %h",
                     to, bad, tck_cnt, cnt0, r, exp_rsp(16, d, 1'b0));
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge CLK);
        rsp_ready = 1'b0;
        n_tests++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL resp_release: vld=%b rdy=%b, want 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_idle_and_zero();
        bit to;
        logic [31:0] r;
        run_cmd(2'd1, 6'd0, 32'h0, 1'b0, 1'b1, to, r);
        n_tests++;
        if (to || tck_cnt !== 0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_0: to=%b tcks=%0d rdy=%b, want 0 0 1", to, tck_cnt, cmd_ready);
        end
        run_cmd(2'd1, 6'd3, 32'h0, 1'b0, 1'b1, to, r);
        n_tests++;
        if (to || tck_cnt !== 3 || rec_tms !== 64'd0 || tgt !== T_RTI) begin
            n_fail++;
            $display("FAIL idle_3: to=%b tcks=%0d tms=%h tgt=%0d, want 0 3 0 %0d", to, tck_cnt, rec_tms, tgt, T_RTI);
        end
        run_cmd(2'd3, 6'd0, 32'hFFFFFFFF, 1'b0, 1'b1, to, r);
        n_tests++;
        if (to || tck_cnt !== 0 || r !== 32'd0) begin
            n_fail++;
            $display("FAIL scan_dr_0: to=%b tcks=%0d rsp=%h, want 0 0 00000000", to, tck_cnt, r);
        end
    endtask

    task automatic test_random();
        bit to;
        logic [31:0] r, d;
        logic [1:0] op;
        logic [5:0] len;
        logic inv;
        int L;
        for (int n = 0; n < 12; n++) begin
            op = 2'($urandom_range(0, 3)); len = 6'($urandom_range(0, 40));
            d = $urandom; inv = 1'($urandom_range(0, 1)); L = sat(len);
            run_cmd(op, len, d, inv, 1'b1, to, r);
            n_tests++;
            if (to || tck_cnt !== exp_cnt(op, L) || rec_tms !== exp_tms(op, L) ||
                rec_tdi !== exp_tdi(op, L, d) || tgt !== T_RTI ||
                dr_sh !== ((op == 2'd3) ? L : 0) || ir_sh !== ((op == 2'd2) ? L : 0) ||
                (op >= 2'd2 && r !== exp_rsp(L, d, inv))) begin
                n_fail++;
                $display("FAIL random_cmd: op=%0d len=%0d to=%b tcks=%0d/%0d tms=%h/%h tdi=%h/%h tgt=%0d rsp=%h/%h",
                         op, len, to, tck_cnt, exp_cnt(op, L), rec_tms, exp_tms(op, L),
                         rec_tdi, exp_tdi(op, L, d), tgt, r, exp_rsp(L, d, inv));
            end
        end
    endtask

    task automatic test_trst_mid();
        bit ok, to;
        logic [31:0] r, d;
        @(negedge CLK);
        tck_cnt = 0; tdo_inv = 1'b0;
        cmd_op = OP_SCAN_DR; cmd_len = 6'd32; cmd_tdi = $urandom; cmd_valid = 1'b1;
        wait_ready(ok);
        @(posedge CLK);
        #1 cmd_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge CLK);
            if (tck_cnt >= 14) ok = 1'b1;
        end
        TRST = 1'b0;
        #1;
        n_tests++;
        if (!ok || TCK !== 1'b0 || TMS !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL trst_mid: reached=%b TCK=%b TMS=%b vld=%b busy=%b, want 1 0 1 0 1",
                     ok, TCK, TMS, rsp_valid, busy);
        end
        repeat (3) @(negedge CLK);
        tck_cnt = 0; rec_tms = '0;
        TRST = 1'b1;
        wait_ready(ok);
        n_tests++;
        if (!ok || tck_cnt !== 6 || rec_tms[5:0] !== 6'b011111 || tgt !== T_RTI) begin
            n_fail++;
            $display("FAIL trst_replay: ready=%b tcks=%0d tms=%b tgt=%0d", ok, tck_cnt, rec_tms[5:0], tgt);
        end
        d = $urandom;
        run_cmd(2'd2, 6'd8, d, 1'b1, 1'b1, to, r);
        n_tests++;
        if (to || r !== exp_rsp(8, d, 1'b1) || tck_cnt !== 14) begin
            n_fail++;
            $display("FAIL trst_next_cmd: to=%b rsp=%h want %h tcks=%0d want 14", to, r, exp_rsp(8, d, 1'b1), tck_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_scan_ir();
        test_scan_dr();
        test_resp_hold();
        test_idle_and_zero();
        test_random();
        test_trst_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
